// File: rtl/axis_probe_master.sv
// axis_probe_master -- on-chip AXI-Stream initiator for probe bring-up and soak.
// Sends fixed-length stimulus packets of LFSR words and checks one response
// packet per stimulus for length / tlast placement and response timeouts.
// Build option: define AXIS_PROBE_MASTER_CSUM_EN to build the rx_checksum
// register; when undefined rx_checksum is tied to zero.
//
// Handshake rule for both streams: a word transfers on a rising clock edge
// where tvalid and tready are both high. The source holds tvalid, tdata and
// tlast stable from the moment tvalid rises until that transfer; the sink may
// raise or drop tready freely. m_axis_tvalid and s_axis_tready are pure state
// decodes, so neither depends combinationally on the partner's signals.
module axis_probe_master #(
  parameter int C_DATA_WIDTH   = 128,
  parameter int TX_WORDS_NUM   = 10,
  parameter int RX_WORDS_NUM   = 10,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      s_axis_aclk,
  input  logic                      s_axis_aresetn,
  input  logic                      start,
  input  logic [15:0]               pkt_num,
  input  logic [31:0]               seed,
  output logic                      busy,
  output logic                      done,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                      m_axis_tlast,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                      s_axis_tlast,
  output logic                      rx_len_err,
  output logic                      timeout_err,
  output logic [15:0]               pkt_cnt,
  output logic [C_DATA_WIDTH-1:0]   rx_checksum,
  output logic [1:0]                dbg_state
);

  localparam int LANES = C_DATA_WIDTH / 32;
  localparam int KEEP_W = C_DATA_WIDTH / 8;
  localparam int TXC_W = $clog2(TX_WORDS_NUM);
  localparam int RXC_W = $clog2(RX_WORDS_NUM);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

  localparam logic [TXC_W-1:0] TX_LAST = TXC_W'(TX_WORDS_NUM - 1);
  localparam logic [RXC_W-1:0] RX_LAST = RXC_W'(RX_WORDS_NUM - 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]      LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RECV = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [31:0]      lfsr_q;
  logic [31:0]      lfsr_next;
  logic [TXC_W-1:0] tx_cnt_q;
  logic [RXC_W-1:0] rx_cnt_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic [15:0]      pkt_cnt_q;
  logic [15:0]      pkt_num_q;
  logic             rx_len_err_q;
  logic             timeout_err_q;

  logic start_go;
  logic run_go;
  logic tx_hs;
  logic tx_last;
  logic rx_hs;
  logic pkt_last;
  logic rx_timeout;

  // Transfer and event decodes shared by the FSM and the datapath.
  assign start_go   = (state_q == ST_IDLE) && start;
  assign run_go     = start_go && (pkt_num != 16'd0);
  assign tx_last    = (tx_cnt_q == TX_LAST);
  assign tx_hs      = (state_q == ST_SEND) && m_axis_tready;
  assign rx_hs      = (state_q == ST_RECV) && s_axis_tvalid;
  assign pkt_last   = ((pkt_cnt_q + 16'd1) == pkt_num_q);
  assign rx_timeout = (state_q == ST_RECV) && !s_axis_tvalid && (to_cnt_q == TO_LAST);

  // Galois step of the stimulus LFSR.
  assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);

  // State register.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and state-decoded stream/status outputs.
  always_comb begin
    state_d       = state_q;
    busy          = 1'b0;
    done          = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (pkt_num != 16'd0) ? ST_SEND : ST_DONE;
        end
      end
      ST_SEND: begin
        busy          = 1'b1;
        m_axis_tvalid = 1'b1;
        m_axis_tkeep  = {KEEP_W{1'b1}};
        m_axis_tlast  = tx_last;
        if (tx_hs && tx_last) begin
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        busy          = 1'b1;
        s_axis_tready = 1'b1;
        if (rx_hs) begin
          if (s_axis_tlast) begin
            state_d = pkt_last ? ST_DONE : ST_SEND;
          end
        end else if (rx_timeout) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Stimulus side: sample the run parameters, step LFSR and word count per transfer.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      lfsr_q    <= 32'h0;
      tx_cnt_q  <= '0;
      pkt_num_q <= 16'h0;
    end else if (start_go) begin
      pkt_num_q <= pkt_num;
      tx_cnt_q  <= '0;
      if (pkt_num != 16'd0) begin
        lfsr_q <= (seed == 32'd0) ? 32'd1 : seed;
      end
    end else if (tx_hs) begin
      lfsr_q   <= lfsr_next;
      tx_cnt_q <= tx_last ? '0 : tx_cnt_q + TXC_W'(1);
    end
  end

  // Response side: word count, length errors, packet count and the idle timeout.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      rx_cnt_q      <= '0;
      to_cnt_q      <= '0;
      pkt_cnt_q     <= 16'h0;
      rx_len_err_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else if (run_go) begin
      rx_cnt_q      <= '0;
      to_cnt_q      <= '0;
      pkt_cnt_q     <= 16'h0;
      rx_len_err_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else if (state_q == ST_RECV) begin
      if (rx_hs) begin
        to_cnt_q <= '0;
        if (s_axis_tlast) begin
          if (rx_cnt_q != RX_LAST) begin
            rx_len_err_q <= 1'b1;
          end
          rx_cnt_q  <= '0;
          pkt_cnt_q <= pkt_cnt_q + 16'd1;
        end else if (rx_cnt_q == RX_LAST) begin
          // Overlong packet: count stays saturated at the last index.
          rx_len_err_q <= 1'b1;
        end else begin
          rx_cnt_q <= rx_cnt_q + RXC_W'(1);
        end
      end else if (rx_timeout) begin
        timeout_err_q <= 1'b1;
        to_cnt_q      <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
    end else begin
      to_cnt_q <= '0;
    end
  end

  assign m_axis_tdata = {LANES{lfsr_q}};
  assign rx_len_err   = rx_len_err_q;
  assign timeout_err  = timeout_err_q;
  assign pkt_cnt      = pkt_cnt_q;
  assign dbg_state    = state_q;

`ifdef AXIS_PROBE_MASTER_CSUM_EN
  logic [C_DATA_WIDTH-1:0] csum_q;

  // Running XOR of every accepted response word in the current run.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      csum_q <= '0;
    end else if (run_go) begin
      csum_q <= '0;
    end else if (rx_hs) begin
      csum_q <= csum_q ^ s_axis_tdata;
    end
  end

  assign rx_checksum = csum_q;

  logic unused_rx_keep;
  assign unused_rx_keep = ^s_axis_tkeep;
`else
  assign rx_checksum = '0;

  logic unused_rx_inputs;
  assign unused_rx_inputs = ^{s_axis_tkeep, s_axis_tdata};
`endif

endmodule

// File: tb/tb_axis_probe_master.sv
// tb_axis_probe_master -- self-checking bench for axis_probe_master.
// Stimulus words are predicted from the LFSR rule and packet counts/errors
// from the response lengths each scenario sends.
module tb_axis_probe_master;

  localparam int W     = 128;
  localparam int KW    = W / 8;
  localparam int LANES = W / 32;
  localparam int TXN   = 10;
  localparam int RXN   = 10;
  localparam int TO    = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   pkt_num = 16'h0;
  logic [31:0]   seed = 32'h0;
  logic          busy, done;
  logic          m_axis_tvalid, m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic [W-1:0]  m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [W-1:0]  s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '1;
  logic          s_axis_tlast = 1'b0;
  logic          rx_len_err, timeout_err;
  logic [15:0]   pkt_cnt;
  logic [W-1:0]  rx_checksum;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int bp_mode  = 0;  // 0: tready high, 1: random tready, 2: tready low

  // Scoreboard: expected stimulus words for the current run, and model checksum.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] csum_exp;

  axis_probe_master #(
    .C_DATA_WIDTH(W), .TX_WORDS_NUM(TXN), .RX_WORDS_NUM(RXN), .TIMEOUT_CYCLES(TO)
  ) dut (
    .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .start(start), .pkt_num(pkt_num),
    .seed(seed), .busy(busy), .done(done),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .rx_len_err(rx_len_err), .timeout_err(timeout_err), .pkt_cnt(pkt_cnt),
    .rx_checksum(rx_checksum), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  // Stimulus-side tready driver, changes just after each rising edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor (records only) ----------------
  logic [W-1:0] obs_data[$];
  logic         obs_last[$];
  int           done_cnt = 0, done_nobusy = 0, stall_breaks = 0, keep_bad = 0;
  int           tvalid_cycles = 0, tready_cycles = 0;
  logic         stall_pending = 1'b0;
  logic [W-1:0] held_data;
  logic         held_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_pending = 1'b0;
    end else begin
      if (stall_pending && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held_data ||
                            m_axis_tlast !== held_last))
        stall_breaks++;
      if (m_axis_tvalid === 1'b1) begin
        tvalid_cycles++;
        if (m_axis_tkeep !== {KW{1'b1}}) keep_bad++;
      end
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
        obs_data.push_back(m_axis_tdata);
        obs_last.push_back(m_axis_tlast);
        stall_pending = 1'b0;
      end else if (m_axis_tvalid === 1'b1) begin
        stall_pending = 1'b1;
        held_data     = m_axis_tdata;
        held_last     = m_axis_tlast;
      end else begin
        stall_pending = 1'b0;
      end
      if (s_axis_tready === 1'b1) tready_cycles++;
      if (done === 1'b1) begin
        done_cnt++;
        if (busy !== 1'b1) done_nobusy++;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic model_stimulus(input logic [31:0] sd, input int npk);
    logic [31:0] s;
    exp_q.delete();
    s = (sd == 32'd0) ? 32'd1 : sd;
    for (int i = 0; i < npk * TXN; i++) begin
      exp_q.push_back({LANES{s}});
      s = lfsr_step(s);
    end
  endtask

  function automatic logic [W-1:0] csum_want();
`ifdef AXIS_PROBE_MASTER_CSUM_EN
    return csum_exp;
`else
    return '0;
`endif
  endfunction

  // ---------------- drivers ----------------
  task automatic do_start(input logic [15:0] pn, input logic [31:0] sd);
    @(posedge clk); #1;
    start = 1'b1; pkt_num = pn; seed = sd;
    @(posedge clk); #1;
    start = 1'b0; pkt_num = 16'($urandom); seed = $urandom;
  endtask

  task automatic wait_rx_hs(output bit ok);
    int c;
    c = 0; ok = 1'b0;
    while (c < 3000) begin
      @(negedge clk);
      if (s_axis_tready === 1'b1) begin ok = 1'b1; break; end
      c++;
    end
    @(posedge clk); #1;
  endtask

  // n_ones < 0: random words; otherwise n_ones all-ones words then 128'h1 words.
  task automatic drive_response(input int n_words, input bit with_last, input int n_ones,
                                output bit ok);
    logic [W-1:0] d;
    bit hs_ok;
    ok = 1'b1;
    for (int i = 0; i < n_words; i++) begin
      if (n_ones < 0) begin
        for (int l = 0; l < LANES; l++) d[32*l +: 32] = $urandom;
      end else begin
        d = (i < n_ones) ? {W{1'b1}} : W'(1);
      end
      s_axis_tvalid = 1'b1; s_axis_tdata = d;
      s_axis_tlast  = with_last && (i == n_words - 1);
      wait_rx_hs(hs_ok);
      if (!hs_ok) begin ok = 1'b0; break; end
      csum_exp = csum_exp ^ d;
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok, output int cyc);
    ok = 1'b0; cyc = 0;
    while (cyc < max_cyc) begin
      @(negedge clk); cyc++;
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
    n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %0b want 0", m_axis_tvalid); end
    n_checks++; if (m_axis_tdata !== '0) begin n_fail++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
    n_checks++; if (m_axis_tkeep !== '0) begin n_fail++; $display("FAIL reset_tkeep: got %h want 0", m_axis_tkeep); end
    n_checks++; if (m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %0b want 0", m_axis_tlast); end
    n_checks++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %0b want 0", s_axis_tready); end
    n_checks++; if (rx_len_err !== 1'b0) begin n_fail++; $display("FAIL reset_len_err: got %0b want 0", rx_len_err); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %0b want 0", timeout_err); end
    n_checks++; if (pkt_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt); end
    n_checks++; if (rx_checksum !== '0) begin n_fail++; $display("FAIL reset_checksum: got %h want 0", rx_checksum); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_packet();
    int b, d0, kb, cyc;
    bit ok_r, ok_d;
    b = obs_data.size(); d0 = done_cnt; kb = keep_bad;
    bp_mode = 0; csum_exp = '0;
    model_stimulus(32'd1, 1);
    do_start(16'd1, 32'd1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_t1: got %0b want 1", busy); end
    n_checks++; if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL single_tvalid_t1: got %0b want 1", m_axis_tvalid); end
    @(posedge clk); #1;
    n_checks++; if (obs_data.size() - b != 1) begin n_fail++; $display("FAIL single_first_xfer: got %0d words want 1", obs_data.size() - b); end
    fork
      drive_response(RXN, 1'b1, -1, ok_r);
      wait_done(400, ok_d, cyc);
    join
    n_checks++; if (!ok_r || !ok_d) begin n_fail++; $display("FAIL single_timeout: got resp_ok=%0b done_ok=%0b want 1 1", ok_r, ok_d); end
    n_checks++; if (obs_data.size() - b != TXN) begin n_fail++; $display("FAIL single_word_count: got %0d want %0d", obs_data.size() - b, TXN); end
    if (obs_data.size() - b == TXN) begin
      n_checks++; if (obs_data[b] !== {LANES{32'h0000_0001}}) begin n_fail++; $display("FAIL single_word0: got %h want all lanes 00000001", obs_data[b]); end
      n_checks++; if (obs_data[b+1] !== {LANES{32'h8020_0003}}) begin n_fail++; $display("FAIL single_word1: got %h want all lanes 80200003", obs_data[b+1]); end
      for (int i = 0; i < TXN; i++) begin
        n_checks++; if (obs_data[b+i] !== exp_q[i] || obs_last[b+i] !== (i == TXN - 1)) begin n_fail++; $display("FAIL single_word[%0d]: got %h last=%0b want %h last=%0b", i, obs_data[b+i], obs_last[b+i], exp_q[i], (i == TXN - 1)); end
      end
    end
    n_checks++; if (pkt_cnt !== 16'd1) begin n_fail++; $display("FAIL single_pkt_cnt: got %0d want 1", pkt_cnt); end
    n_checks++; if (rx_len_err !== 1'b0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL single_errs: got len=%0b to=%0b want 0 0", rx_len_err, timeout_err); end
    n_checks++; if (done_cnt - d0 != 1 || done_nobusy != 0) begin n_fail++; $display("FAIL single_done: got %0d pulses (nobusy %0d) want 1 (0)", done_cnt - d0, done_nobusy); end
    n_checks++; if (keep_bad - kb != 0) begin n_fail++; $display("FAIL single_tkeep: got %0d bad cycles want 0", keep_bad - kb); end
    n_checks++; if (rx_checksum !== csum_want()) begin n_fail++; $display("FAIL single_checksum: got %h want %h", rx_checksum, csum_want()); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %0b want 0", busy); end
  endtask

  task automatic test_backpressure();
    int b, sb, cyc;
    bit ok_r, ok_d, ok_all;
    logic [31:0] sd;
    b = obs_data.size(); sb = stall_breaks; ok_all = 1'b1;
    sd = $urandom; csum_exp = '0;
    model_stimulus(sd, 3);
    bp_mode = 1;
    do_start(16'd3, sd);
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          drive_response(RXN, 1'b1, -1, ok_r);
          ok_all = ok_all & ok_r;
        end
      end
      wait_done(3000, ok_d, cyc);
    join
    bp_mode = 0;
    n_checks++; if (!ok_all || !ok_d) begin n_fail++; $display("FAIL bp_timeout: got resp_ok=%0b done_ok=%0b want 1 1", ok_all, ok_d); end
    n_checks++; if (obs_data.size() - b != 3 * TXN) begin n_fail++; $display("FAIL bp_word_count: got %0d want %0d", obs_data.size() - b, 3 * TXN); end
    if (obs_data.size() - b == 3 * TXN) begin
      for (int i = 0; i < 3 * TXN; i++) begin
        n_checks++; if (obs_data[b+i] !== exp_q[i] || obs_last[b+i] !== ((i % TXN) == TXN - 1)) begin n_fail++; $display("FAIL bp_word[%0d]: got %h last=%0b want %h last=%0b", i, obs_data[b+i], obs_last[b+i], exp_q[i], ((i % TXN) == TXN - 1)); end
      end
    end
    n_checks++; if (stall_breaks - sb != 0) begin n_fail++; $display("FAIL bp_stall_stable: got %0d violations want 0", stall_breaks - sb); end
    n_checks++; if (pkt_cnt !== 16'd3) begin n_fail++; $display("FAIL bp_pkt_cnt: got %0d want 3", pkt_cnt); end
    n_checks++; if (rx_checksum !== csum_want()) begin n_fail++; $display("FAIL bp_checksum: got %h want %h", rx_checksum, csum_want()); end
  endtask

  task automatic test_len_err();
    int b, d0, cyc;
    bit ok_r1, ok_r2, ok_d;
    b = obs_data.size(); d0 = done_cnt; csum_exp = '0;
    bp_mode = 0;
    do_start(16'd2, $urandom);
    fork
      begin
        drive_response(8, 1'b1, -1, ok_r1);
        drive_response(RXN, 1'b1, -1, ok_r2);
      end
      wait_done(1000, ok_d, cyc);
    join
    n_checks++; if (!ok_r1 || !ok_r2 || !ok_d) begin n_fail++; $display("FAIL short_timeout: got %0b%0b%0b want 111", ok_r1, ok_r2, ok_d); end
    n_checks++; if (rx_len_err !== 1'b1) begin n_fail++; $display("FAIL short_len_err: got %0b want 1", rx_len_err); end
    n_checks++; if (pkt_cnt !== 16'd2 || obs_data.size() - b != 2 * TXN) begin n_fail++; $display("FAIL short_continue: got pkts=%0d words=%0d want 2 %0d", pkt_cnt, obs_data.size() - b, 2 * TXN); end
    n_checks++; if (timeout_err !== 1'b0 || done_cnt - d0 != 1) begin n_fail++; $display("FAIL short_done: got to=%0b pulses=%0d want 0 1", timeout_err, done_cnt - d0); end
    do_start(16'd1, $urandom);
    n_checks++; if (rx_len_err !== 1'b0) begin n_fail++; $display("FAIL len_err_clear: got %0b want 0", rx_len_err); end
    fork
      drive_response(RXN + 2, 1'b1, -1, ok_r1);
      wait_done(1000, ok_d, cyc);
    join
    n_checks++; if (!ok_r1 || !ok_d) begin n_fail++; $display("FAIL long_timeout: got %0b%0b want 11", ok_r1, ok_d); end
    n_checks++; if (rx_len_err !== 1'b1 || pkt_cnt !== 16'd1) begin n_fail++; $display("FAIL long_len_err: got len=%0b pkts=%0d want 1 1", rx_len_err, pkt_cnt); end
  endtask

  task automatic test_timeout();
    int d0, cyc;
    bit ok_r, ok_d;
    d0 = done_cnt;
    bp_mode = 0;
    do_start(16'd2, $urandom);
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %0b want 0", timeout_err); end
    wait_done(3000, ok_d, cyc);
    n_checks++; if (!ok_d) begin n_fail++; $display("FAIL timeout_done_seen: got no done want done"); end
    n_checks++; if (cyc < TO + TXN - 4 || cyc > TO + TXN + 6) begin n_fail++; $display("FAIL timeout_latency: got %0d cycles want about %0d", cyc, TO + TXN + 1); end
    n_checks++; if (timeout_err !== 1'b1 || pkt_cnt !== 16'd0 || rx_len_err !== 1'b0) begin n_fail++; $display("FAIL timeout_flags: got to=%0b pkts=%0d len=%0b want 1 0 0", timeout_err, pkt_cnt, rx_len_err); end
    n_checks++; if (done_cnt - d0 != 1 || busy !== 1'b0) begin n_fail++; $display("FAIL timeout_end: got pulses=%0d busy=%0b want 1 0", done_cnt - d0, busy); end
    do_start(16'd1, $urandom);
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_clear2: got %0b want 0", timeout_err); end
    fork
      drive_response(4, 1'b0, -1, ok_r);
      wait_done(3000, ok_d, cyc);
    join
    n_checks++; if (!ok_r || !ok_d) begin n_fail++; $display("FAIL partial_wait: got %0b%0b want 11", ok_r, ok_d); end
    n_checks++; if (timeout_err !== 1'b1 || pkt_cnt !== 16'd0 || rx_len_err !== 1'b0) begin n_fail++; $display("FAIL partial_flags: got to=%0b pkts=%0d len=%0b want 1 0 0", timeout_err, pkt_cnt, rx_len_err); end
  endtask

  task automatic test_checksum();
    int cyc;
    bit ok_r1, ok_r2, ok_d;
    csum_exp = '0;
    bp_mode = 0;
    do_start(16'd2, $urandom);
    n_checks++; if (rx_checksum !== '0) begin n_fail++; $display("FAIL csum_clear: got %h want 0", rx_checksum); end
    fork
      begin
        drive_response(RXN, 1'b1, 7, ok_r1);
        drive_response(RXN, 1'b1, 4, ok_r2);
      end
      wait_done(1000, ok_d, cyc);
    join
    n_checks++; if (!ok_r1 || !ok_r2 || !ok_d) begin n_fail++; $display("FAIL csum_timeout: got %0b%0b%0b want 111", ok_r1, ok_r2, ok_d); end
    n_checks++; if (rx_checksum !== csum_want()) begin n_fail++; $display("FAIL csum_value: got %h want %h", rx_checksum, csum_want()); end
    n_checks++; if (pkt_cnt !== 16'd2 || rx_len_err !== 1'b0) begin n_fail++; $display("FAIL csum_pkts: got pkts=%0d len=%0b want 2 0", pkt_cnt, rx_len_err); end
  endtask

  task automatic test_mid_reset();
    bp_mode = 2;
    do_start(16'd1, $urandom);
    n_checks++; if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL mrst_send_valid: got %0b want 1", m_axis_tvalid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mrst_send_drop: got tvalid=%0b busy=%0b want 0 0", m_axis_tvalid, busy); end
    @(posedge clk); #1 rst_n = 1'b1;
    bp_mode = 0;
    do_start(16'd1, $urandom);
    repeat (12) @(posedge clk);
    #1;
    n_checks++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL mrst_recv_ready: got %0b want 1", s_axis_tready); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (s_axis_tready !== 1'b0 || busy !== 1'b0 || pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL mrst_recv_drop: got tready=%0b busy=%0b pkts=%0d want 0 0 0", s_axis_tready, busy, pkt_cnt); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored();
    int b, d0, cyc;
    bit ok_r, ok_d;
    logic [31:0] sd;
    b = obs_data.size(); d0 = done_cnt;
    sd = $urandom; csum_exp = '0;
    model_stimulus(sd, 1);
    bp_mode = 0;
    do_start(16'd1, sd);
    @(posedge clk); #1;
    start = 1'b1; pkt_num = 16'd5; seed = sd ^ 32'h1;
    @(posedge clk); #1;
    start = 1'b0;
    fork
      drive_response(RXN, 1'b1, -1, ok_r);
      wait_done(1000, ok_d, cyc);
    join
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (!ok_r || !ok_d) begin n_fail++; $display("FAIL ign_timeout: got %0b%0b want 11", ok_r, ok_d); end
    n_checks++; if (obs_data.size() - b != TXN) begin n_fail++; $display("FAIL ign_word_count: got %0d want %0d", obs_data.size() - b, TXN); end
    if (obs_data.size() - b == TXN) begin
      for (int i = 0; i < TXN; i++) begin
        n_checks++; if (obs_data[b+i] !== exp_q[i]) begin n_fail++; $display("FAIL ign_word[%0d]: got %h want %h", i, obs_data[b+i], exp_q[i]); end
      end
    end
    n_checks++; if (pkt_cnt !== 16'd1 || done_cnt - d0 != 1 || busy !== 1'b0) begin n_fail++; $display("FAIL ign_result: got pkts=%0d pulses=%0d busy=%0b want 1 1 0", pkt_cnt, done_cnt - d0, busy); end
  endtask

  task automatic test_zero_pkts();
    int b, d0, tv0, tr0;
    b = obs_data.size(); d0 = done_cnt; tv0 = tvalid_cycles; tr0 = tready_cycles;
    do_start(16'd0, $urandom);
    n_checks++; if (done !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL zero_done_t1: got done=%0b busy=%0b want 1 1", done, busy); end
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_idle: got done=%0b busy=%0b want 0 0", done, busy); end
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL zero_pulses: got %0d want 1", done_cnt - d0); end
    n_checks++; if (tvalid_cycles - tv0 != 0 || tready_cycles - tr0 != 0 || obs_data.size() - b != 0) begin n_fail++; $display("FAIL zero_traffic: got tvalid=%0d tready=%0d cycles want 0 0", tvalid_cycles - tv0, tready_cycles - tr0); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_packet();
    test_backpressure();
    test_len_err();
    test_timeout();
    test_checksum();
    test_mid_reset();
    test_start_ignored();
    test_zero_pkts();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
